core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the PC value loaded at reset (instruction-word index).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port halt, input, 1, meaning "do not start a new instruction".
REQ-005 SHALL have stage-enable outputs fetch_en, decode_en, exec_en, mem_en, write_en, each 1 bit, each a single-cycle start pulse.
REQ-006 SHALL have stage-done inputs fetch_done, decode_done, exec_done, mem_done, write_done, each 1 bit.
REQ-007 SHALL have port pc, output, 32, the address of the instruction in flight, valid for the fetch stage.
REQ-008 SHALL have port exec_pc_n, input, 32, the next PC from execute, sampled when exec_done is accepted.
REQ-009 SHALL have ports trap (input, 1) and trap_vec (input, 32), both sampled when exec_done is accepted.
REQ-010 SHALL have ports state (output, 3, current state encoding) and busy (output, 1, high in any state except IDLE).

Function
REQ-011 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4 and WRITE=5; encodings 6 and 7 SHALL return to IDLE on the next cycle.
REQ-012 SHALL assert the enable of a stage for exactly the first cycle spent in that stage's state, then hold it low.
REQ-013 SHALL ignore a stage's done input in the cycle its enable is high, and in every state other than that stage's own state.
REQ-014 SHALL advance on an accepted done in strict order: FETCH->DECODE->EXEC->MEM->WRITE, with the new enable pulsing in the following cycle; minimum latency is 2 cycles per stage, 10 cycles per instruction.
REQ-015 SHALL wait indefinitely in a stage until its done is accepted, with no timeout.
REQ-016 SHALL, on an accepted exec_done, latch exec_pc_n into pc_next_q, and latch trap plus trap_vec.
REQ-017 SHALL, on an accepted write_done, update pc to trap_vec_q if trap_q=1, else to pc_next_q, then clear trap_q.
REQ-018 SHALL change pc only in the cycle given by REQ-017 (and at reset).
REQ-019 SHALL, on an accepted write_done, go to IDLE if halt=1, else to FETCH.
REQ-020 SHALL, in IDLE with halt=0, go to FETCH on the next cycle; halt SHALL NOT affect an instruction already in flight.
REQ-021 SHALL apply pc arithmetic as a 32-bit wrap; exec_pc_n=32'hFFFFFFFF SHALL be taken verbatim.

Reset
REQ-022 SHALL, while rstn=0, force state=IDLE, all enables=0, busy=0, pc=RESET_PC, pc_next_q=0, trap_q=0, and all counters=0.
REQ-023 SHALL, when rstn asserts mid-instruction, abandon that instruction with no pc update, and restart from IDLE after release.

Configuration
REQ-024 SHALL, with macro CORE_SEQUENCER_PERF_EN defined, add outputs cycle_cnt (64) and instret_cnt (64).
- cycle_cnt increments every cycle busy=1.
- instret_cnt increments on each accepted write_done, including trapped instructions.
- Both wrap at 2^64.
REQ-025 SHALL, without CORE_SEQUENCER_PERF_EN, omit both ports and the counter logic entirely, with identical behaviour otherwise.

Verification
REQ-026 Reset-release test: rstn low->high, halt=0, every done returned 1 cycle after its enable -> fetch_en pulses at cycle 2 with pc=0; each enable is a single cycle; 10 cycles per instruction.
REQ-027 Sequential-PC test: three instructions with exec_pc_n=1,2,3 -> pc reads 0,1,2,3 and changes only in the cycle after write_done.
REQ-028 Trap test: trap=1, trap_vec=47, exec_pc_n=9 on exec_done -> after write_done pc=47; the next instruction with trap=0, exec_pc_n=48 -> pc=48.
REQ-029 Done-filtering test:
- decode_done held high throughout FETCH -> no advance.
- fetch_done asserted in the same cycle as fetch_en -> ignored.
- fetch_done one cycle later -> advance.
REQ-030 Halt and mid-instruction reset test: halt=1 asserted during EXEC -> the instruction completes, then state=IDLE, busy=0, with no fetch_en until halt=0. Then rstn pulsed low during MEM -> pc returns to RESET_PC, all enables are 0 immediately, and with PERF_EN instret_cnt=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH..WRITE with done handshakes.
// Ports: clk/rstn, halt, *_en pulses, *_done, pc, exec_pc_n, trap/trap_vec,
// state, busy; CORE_SEQUENCER_PERF_EN adds cycle_cnt and instret_cnt.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        halt,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        write_en,
  input  logic        fetch_done,
  input  logic        decode_done,
  input  logic        exec_done,
  input  logic        mem_done,
  input  logic        write_done,
  output logic [31:0] pc,
  input  logic [31:0] exec_pc_n,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  output logic [2:0]  state,
  output logic        busy
`ifdef CORE_SEQUENCER_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WRITE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_first;
  logic [31:0] r_pc;
  logic [31:0] r_pc_next;
  logic        r_trap;
  logic [31:0] r_trap_vec;
  logic        w_exec_acc;
  logic        w_write_acc;

  // r_first marks the first cycle in a state: the enable
  // cycle, during which the stage's done is ignored.
  always_comb begin
    w_next      = r_state;
    w_exec_acc  = 1'b0;
    w_write_acc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!halt) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done && !r_first) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (decode_done && !r_first) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_exec_acc = exec_done && !r_first;
        if (w_exec_acc) w_next = S_MEM;
      end
      S_MEM: begin
        if (mem_done && !r_first) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_write_acc = write_done && !r_first;
        if (w_write_acc) w_next = halt ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_pc_next  <= 32'd0;
      r_trap     <= 1'b0;
      r_trap_vec <= 32'd0;
    end else begin
      if (w_exec_acc) begin
        r_pc_next  <= exec_pc_n;
        r_trap     <= trap;
        r_trap_vec <= trap_vec;
      end
      if (w_write_acc) begin
        r_pc   <= r_trap ? r_trap_vec : r_pc_next;
        r_trap <= 1'b0;
      end
    end
  end

  assign fetch_en  = r_first && (r_state == S_FETCH);
  assign decode_en = r_first && (r_state == S_DECODE);
  assign exec_en   = r_first && (r_state == S_EXEC);
  assign mem_en    = r_first && (r_state == S_MEM);
  assign write_en  = r_first && (r_state == S_WRITE);
  assign pc        = r_pc;
  assign state     = r_state;
  assign busy      = (r_state != S_IDLE);

`ifdef CORE_SEQUENCER_PERF_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      if (busy) r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (w_write_acc) r_instret_cnt <= r_instret_cnt + 64'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
